similarity_multi_mapper: RTL and testbench

- Successor to the single-pair similarity direct mapper. Compares one query hypervector in dual-port RAM against up to MAX_CLASSES class hypervectors at a fixed stride.
- Each pair is streamed interleaved (query word, class word) into one external cosine-similarity kernel.
- Every per-class AA/BB/AB triple is reported, and the argmax-AB class is tracked.
- Sits between the hypervector dpRAM and the CosineSimilarity kernel as the classifier back end.

---
 rtl/similarity_multi_mapper.sv | 198 +++++++++++++++++++
 tb/tb_similarity_multi_mapper.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/similarity_multi_mapper.sv
// Classifier back end: streams one query hypervector against up to MAX_CLASSES class
// hypervectors through an external cosine-similarity kernel, reporting every result and the argmax-AB class.
module similarity_multi_mapper #(
  parameter int HV_DATA_WIDTH    = 32,
  parameter int HV_ADDRESS_WIDTH = 8,
  parameter int MAX_CLASSES      = 16,
  parameter int CLASS_IDX_WIDTH  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [HV_ADDRESS_WIDTH-1:0] query_base,
  input  logic [HV_ADDRESS_WIDTH-1:0] class_base,
  input  logic [HV_ADDRESS_WIDTH-1:0] class_stride,
  input  logic [CLASS_IDX_WIDTH:0]    num_classes,
  input  logic [HV_ADDRESS_WIDTH-1:0] hv_len,
  output logic                        we_n,
  output logic [HV_ADDRESS_WIDTH-1:0] address,
  input  logic [HV_DATA_WIDTH-1:0]    data_rd,
  output logic                        k_valid,
  output logic                        k_first,
  output logic                        k_last,
  output logic [HV_DATA_WIDTH-1:0]    k_data_in,
  input  logic [HV_DATA_WIDTH-1:0]    k_AA_out,
  input  logic [HV_DATA_WIDTH-1:0]    k_BB_out,
  input  logic [HV_DATA_WIDTH-1:0]    k_AB_out,
  input  logic                        k_ready,
  input  logic                        k_done,
  output logic                        busy,
  output logic                        res_valid,
  output logic [CLASS_IDX_WIDTH-1:0]  res_idx,
  output logic [HV_DATA_WIDTH-1:0]    res_AA,
  output logic [HV_DATA_WIDTH-1:0]    res_BB,
  output logic [HV_DATA_WIDTH-1:0]    res_AB,
  output logic                        done,
  output logic                        error,
  output logic [CLASS_IDX_WIDTH-1:0]  best_idx,
  output logic [HV_DATA_WIDTH-1:0]    best_AB
);

  localparam int CW = CLASS_IDX_WIDTH + 1;
  localparam logic [CLASS_IDX_WIDTH:0]    MAX_CNT = CW'(MAX_CLASSES);
  localparam logic [CLASS_IDX_WIDTH:0]    CLS_ONE = CW'(1);
  localparam logic [HV_ADDRESS_WIDTH-1:0] ADR_ONE = HV_ADDRESS_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, ADDR, CAP, SEND, WAIT_K, RESULT, FINISH} state_t;

  state_t                      state_q, state_d;
  logic [HV_ADDRESS_WIDTH-1:0] query_q, stride_q, len_q, class_ptr_q, word_q;
  logic [CLASS_IDX_WIDTH:0]    nclass_q, cls_q;
  logic                        phase_q, err_q;
  logic [HV_DATA_WIDTH-1:0]    data_q, aa_q, bb_q, ab_q, best_ab_q;
  logic [CLASS_IDX_WIDTH-1:0]  res_idx_q, best_idx_q;

  logic                        illegal, last_word, better;
  logic [CLASS_IDX_WIDTH:0]    cls_next;
  logic [HV_ADDRESS_WIDTH-1:0] addr_cur;

  assign illegal   = (num_classes == '0) || (num_classes > MAX_CNT) || (hv_len == '0);
  assign last_word = (word_q == len_q - ADR_ONE);
  assign cls_next  = cls_q + CLS_ONE;
  assign better    = (cls_q == '0) || (ab_q > best_ab_q);
  // class_ptr_q tracks class_base + c*class_stride incrementally; all sums wrap at the address width
  assign addr_cur  = phase_q ? (class_ptr_q + word_q) : (query_q + word_q);

  assign res_idx  = res_idx_q;
  assign res_AA   = aa_q;
  assign res_BB   = bb_q;
  assign res_AB   = ab_q;
  assign best_idx = best_idx_q;
  assign best_AB  = best_ab_q;

  always_comb begin
    state_d   = state_q;
    we_n      = 1'b1;
    address   = '0;
    k_valid   = 1'b0;
    k_first   = 1'b0;
    k_last    = 1'b0;
    k_data_in = '0;
    busy      = 1'b0;
    res_valid = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = illegal ? FINISH : ADDR;
      end
      ADDR: begin
        busy    = 1'b1;
        address = addr_cur;
        state_d = CAP;
      end
      CAP: begin
        busy    = 1'b1;
        address = addr_cur;
        state_d = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        k_valid   = 1'b1;
        k_data_in = data_q;
        k_first   = !phase_q && (word_q == '0);
        k_last    = phase_q && last_word;
        if (k_ready) state_d = (phase_q && last_word) ? WAIT_K : ADDR;
      end
      WAIT_K: begin
        busy = 1'b1;
        if (k_done) state_d = RESULT;
      end
      RESULT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        state_d   = (cls_next < nclass_q) ? ADDR : FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        error   = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      query_q     <= '0;
      stride_q    <= '0;
      len_q       <= '0;
      class_ptr_q <= '0;
      word_q      <= '0;
      nclass_q    <= '0;
      cls_q       <= '0;
      phase_q     <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= '0;
      aa_q        <= '0;
      bb_q        <= '0;
      ab_q        <= '0;
      res_idx_q   <= '0;
      best_idx_q  <= '0;
      best_ab_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            query_q     <= query_base;
            class_ptr_q <= class_base;
            stride_q    <= class_stride;
            nclass_q    <= num_classes;
            len_q       <= hv_len;
            word_q      <= '0;
            phase_q     <= 1'b0;
            cls_q       <= '0;
            err_q       <= illegal;
            aa_q        <= '0;
            bb_q        <= '0;
            ab_q        <= '0;
            res_idx_q   <= '0;
            best_idx_q  <= '0;
            best_ab_q   <= '0;
          end
        end
        CAP: data_q <= data_rd;
        SEND: begin
          if (k_ready) begin
            if (phase_q) begin
              phase_q <= 1'b0;
              word_q  <= last_word ? '0 : word_q + ADR_ONE;
            end else begin
              phase_q <= 1'b1;
            end
          end
        end
        WAIT_K: begin
          if (k_done) begin
            aa_q      <= k_AA_out;
            bb_q      <= k_BB_out;
            ab_q      <= k_AB_out;
            res_idx_q <= cls_q[CLASS_IDX_WIDTH-1:0];
          end
        end
        RESULT: begin
          if (better) begin
            best_idx_q <= res_idx_q;
            best_ab_q  <= ab_q;
          end
          cls_q       <= cls_next;
          class_ptr_q <= class_ptr_q + stride_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_similarity_multi_mapper.sv
// Scoreboard bench for similarity_multi_mapper: dpRAM and kernel models, expected words/results
// derived from memory contents, monitors popping expectations as the DUT presents them.
module tb_similarity_multi_mapper;
  localparam int DW = 32, AW = 8, MAXC = 16, CIW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset = 1'b1, start = 1'b0;
  logic [AW-1:0]  query_base = '0, class_base = '0, class_stride = '0, hv_len = '0;
  logic [CIW:0]   num_classes = '0;
  logic           we_n;
  logic [AW-1:0]  address;
  logic [DW-1:0]  data_rd = '0;
  logic           k_valid, k_first, k_last;
  logic [DW-1:0]  k_data_in;
  logic [DW-1:0]  k_AA_out = '0, k_BB_out = '0, k_AB_out = '0;
  logic           k_ready = 1'b1, k_done = 1'b0;
  logic           busy, res_valid, done, error;
  logic [CIW-1:0] res_idx, best_idx;
  logic [DW-1:0]  res_AA, res_BB, res_AB, best_AB;

  similarity_multi_mapper #(
    .HV_DATA_WIDTH(DW), .HV_ADDRESS_WIDTH(AW), .MAX_CLASSES(MAXC), .CLASS_IDX_WIDTH(CIW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .query_base(query_base), .class_base(class_base),
    .class_stride(class_stride), .num_classes(num_classes), .hv_len(hv_len), .we_n(we_n),
    .address(address), .data_rd(data_rd), .k_valid(k_valid), .k_first(k_first), .k_last(k_last),
    .k_data_in(k_data_in), .k_AA_out(k_AA_out), .k_BB_out(k_BB_out), .k_AB_out(k_AB_out),
    .k_ready(k_ready), .k_done(k_done), .busy(busy), .res_valid(res_valid), .res_idx(res_idx),
    .res_AA(res_AA), .res_BB(res_BB), .res_AB(res_AB), .done(done), .error(error),
    .best_idx(best_idx), .best_AB(best_AB)
  );

  logic [DW-1:0] mem [256];
  always @(posedge clk) data_rd <= mem[address];

  typedef struct { logic [CIW-1:0] idx; logic [DW-1:0] aa, bb, ab; } res_t;
  typedef struct { logic err; logic [CIW-1:0] idx; logic [DW-1:0] ab; } done_t;
  typedef struct { logic [DW-1:0] data; logic first, last; } word_t;
  res_t  exp_res[$];
  done_t exp_done[$];
  word_t exp_word[$];

  int checks = 0, errors = 0;
  int done_cnt = 0, kv_cnt = 0, lastcnt = 0;
  int kmode = 0, kdelay = 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // Kernel model: accepts words, checks them against the expected stream, accumulates, pulses k_done.
  logic          prev_stall = 1'b0, pending = 1'b0;
  logic [DW-1:0] stall_data = '0, ka = '0, acc_aa = '0, acc_bb = '0, acc_ab = '0;
  int            wic = 0, stall_cnt = 0, pend = 0;
  word_t         w;
  always @(negedge clk) begin
    k_done = 1'b0;
    if (reset) begin
      prev_stall = 1'b0; pending = 1'b0; wic = 0; stall_cnt = 0; k_ready = 1'b1;
    end else begin
      if (pending) begin
        if (pend <= 1) begin
          k_done = 1'b1; k_AA_out = acc_aa; k_BB_out = acc_bb; k_AB_out = acc_ab; pending = 1'b0;
        end else pend--;
      end
      if (prev_stall) begin
        chk("hold_k_valid", k_valid, 1);
        chk("hold_k_data", k_data_in, stall_data);
      end
      case (kmode)
        0: k_ready = 1'b1;
        1: k_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (k_valid && wic == 1 && stall_cnt < 5) begin k_ready = 1'b0; stall_cnt++; end
          else k_ready = 1'b1;
        end
      endcase
      if (k_valid && k_ready) begin
        kv_cnt++;
        if (exp_word.size() == 0) fail("unexpected_kernel_word");
        else begin
          w = exp_word.pop_front();
          chk("word_data", k_data_in, w.data);
          chk("word_first", DW'(k_first), DW'(w.first));
          chk("word_last", DW'(k_last), DW'(w.last));
        end
        if (k_first) begin acc_aa = '0; acc_bb = '0; acc_ab = '0; wic = 0; stall_cnt = 0; end
        if (wic % 2 == 0) ka = k_data_in;
        else begin
          acc_aa += ka * ka; acc_bb += k_data_in * k_data_in; acc_ab += ka * k_data_in;
        end
        wic++;
        if (k_last) begin pending = 1'b1; pend = kdelay; lastcnt++; end
        prev_stall = 1'b0;
      end else begin
        prev_stall = k_valid;
        stall_data = k_data_in;
      end
    end
  end

  // Result monitor
  res_t  r;
  done_t d;
  always @(negedge clk) begin
    if (!reset) begin
      if (res_valid) begin
        if (exp_res.size() == 0) fail("unexpected_res_valid");
        else begin
          r = exp_res.pop_front();
          chk("res_idx", DW'(res_idx), DW'(r.idx));
          chk("res_AA", res_AA, r.aa);
          chk("res_BB", res_BB, r.bb);
          chk("res_AB", res_AB, r.ab);
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_done.size() == 0) fail("unexpected_done");
        else begin
          d = exp_done.pop_front();
          chk("done_error", DW'(error), DW'(d.err));
          chk("best_idx", DW'(best_idx), DW'(d.idx));
          chk("best_AB", best_AB, d.ab);
          chk("busy_low_with_done", DW'(busy), 0);
        end
      end
    end
  end

  task automatic check_idle_zero();
    chk("rst_we_n", DW'(we_n), 1);
    chk("rst_busy", DW'(busy), 0);
    chk("rst_done", DW'(done), 0);
    chk("rst_res_valid", DW'(res_valid), 0);
    chk("rst_k_valid", DW'(k_valid), 0);
    chk("rst_address", DW'(address), 0);
    chk("rst_k_data_in", k_data_in, 0);
    chk("rst_res_AB", res_AB, 0);
    chk("rst_best_AB", best_AB, 0);
  endtask

  task automatic fill_mem(input int maxv);
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom_range(0, maxv));
  endtask

  // abort_cls >= 0: assert reset while waiting for the kernel result of that class.
  task automatic run(input logic [AW-1:0] qb, input logic [AW-1:0] cb, input logic [AW-1:0] st,
                     input logic [CIW:0] nc, input logic [AW-1:0] len, input int mode,
                     input int dly, input bit poke, input int abort_cls);
    logic [DW-1:0]  aa, bb, ab, bab, qw, cw;
    logic [CIW-1:0] bidx;
    bit             ill, finished;
    int             d0, s_kv, l0;
    ill = (nc == 0) || (nc > MAXC) || (len == 0);
    kmode = mode; kdelay = dly;
    bab = '0; bidx = '0;
    if (ill) exp_done.push_back('{1'b1, '0, '0});
    else begin
      for (int c = 0; c < int'(nc); c++) begin
        aa = '0; bb = '0; ab = '0;
        for (int i = 0; i < int'(len); i++) begin
          qw = mem[(int'(qb) + i) % 256];
          cw = mem[(int'(cb) + c * int'(st) + i) % 256];
          exp_word.push_back('{qw, i == 0, 1'b0});
          exp_word.push_back('{cw, 1'b0, i == int'(len) - 1});
          aa += qw * qw; bb += cw * cw; ab += qw * cw;
        end
        exp_res.push_back('{CIW'(c), aa, bb, ab});
        if (c == 0 || ab > bab) begin bab = ab; bidx = CIW'(c); end
      end
      exp_done.push_back('{1'b0, bidx, bab});
    end
    @(negedge clk);
    query_base = qb; class_base = cb; class_stride = st; num_classes = nc; hv_len = len;
    start = 1'b1;
    s_kv = kv_cnt; d0 = done_cnt; l0 = lastcnt;
    @(negedge clk);
    start = 1'b0;
    if (ill) begin
      chk("illegal_done_latency", DW'(done), 1);
      chk("illegal_error", DW'(error), 1);
    end
    finished = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      if (done_cnt != d0) begin finished = 1'b1; break; end
      if (abort_cls >= 0 && lastcnt - l0 >= abort_cls + 1) begin
        @(negedge clk);
        reset = 1'b1;
        exp_res.delete(); exp_done.delete(); exp_word.delete();
        @(negedge clk);
        check_idle_zero();
        reset = 1'b0;
        for (int j = 0; j < 4; j++) @(negedge clk);
        chk("no_done_after_abort", DW'(done_cnt), DW'(d0));
        return;
      end
      if (poke && !ill && k == 3) begin
        start = 1'b1; query_base = ~qb; num_classes = 1; hv_len = 1;
      end
      if (poke && !ill && k == 4) begin
        start = 1'b0; query_base = qb; num_classes = nc; hv_len = len;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!finished) begin
      fail("run_timeout");
      exp_res.delete(); exp_done.delete(); exp_word.delete();
    end
    if (ill) chk("illegal_no_kernel_traffic", DW'(kv_cnt), DW'(s_kv));
    chk("res_queue_drained", DW'(exp_res.size()), 0);
    chk("word_queue_drained", DW'(exp_word.size()), 0);
    @(negedge clk);
  endtask

  task automatic load_test1();
    mem[0] = 3; mem[1] = 5; mem[4] = 2; mem[5] = 7;
  endtask

  initial begin
    fill_mem(255);
    repeat (3) @(negedge clk);
    check_idle_zero();
    reset = 1'b0;
    @(negedge clk);

    // basic single-class run
    load_test1();
    run(8'd0, 8'd4, 8'd4, 5'd1, 8'd2, 0, 1, 1'b0, -1);
    // four classes with an AB tie between idx 1 and 2
    mem[100] = 1; mem[101] = 0;
    mem[4] = 10; mem[5] = 3; mem[8] = 40; mem[9] = 9;
    mem[12] = 40; mem[13] = 1; mem[16] = 7; mem[17] = 2;
    run(8'd100, 8'd4, 8'd4, 5'd4, 8'd2, 0, 2, 1'b0, -1);
    chk("tie_keeps_lower_idx", DW'(best_idx), 1);
    chk("tie_best_AB", best_AB, 40);
    // same run with a 5-cycle back-pressure stall on word 1
    run(8'd100, 8'd4, 8'd4, 5'd4, 8'd2, 2, 1, 1'b0, -1);
    // illegal parameters
    run(8'd0, 8'd4, 8'd4, 5'd0, 8'd2, 0, 1, 1'b0, -1);
    run(8'd0, 8'd4, 8'd4, 5'd1, 8'd0, 0, 1, 1'b0, -1);
    run(8'd0, 8'd4, 8'd4, 5'd17, 8'd2, 0, 1, 1'b0, -1);
    // class address wrap past 255
    fill_mem(255);
    run(8'd40, 8'd250, 8'd4, 5'd2, 8'd3, 1, 2, 1'b0, -1);
    // abort in WAIT_K of class 2, then rerun the basic case with start pokes while busy
    run(8'd17, 8'd60, 8'd9, 5'd4, 8'd2, 1, 4, 1'b0, 2);
    load_test1();
    run(8'd0, 8'd4, 8'd4, 5'd1, 8'd2, 0, 1, 1'b1, -1);

    for (int n = 0; n < 25; n++) begin
      fill_mem((n % 2 == 0) ? 7 : 255);
      run(AW'($urandom), AW'($urandom), AW'($urandom_range(0, 40)),
          (CIW + 1)'($urandom_range(1, MAXC)), AW'($urandom_range(1, 4)),
          int'($urandom_range(0, 2)), int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
